// File: rtl/cs_rst_seq_pkg.sv
// Shared types and bit-search helpers for the capture/streaming reset sequencer.
package cs_rst_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // The encoding lets a request escalate the mode with a plain OR (DEV -> ALL, never back).
  typedef enum logic {
    MODE_DEV = 1'b0,
    MODE_ALL = 1'b1
  } mode_e;

  localparam logic [5:0] NONE = 6'd32;

  function automatic logic [5:0] first_set(input logic [31:0] mask);
    logic [5:0] r;
    r = NONE;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i]) r = 6'(i);
    end
    return r;
  endfunction

  function automatic logic [5:0] next_set(input logic [31:0] mask, input logic [5:0] idx);
    logic [5:0] r;
    r = NONE;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i] && (i > int'(idx))) r = 6'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/cs_rst_seq.sv
// Reset sequencer: stretches ALL/DEV reset requests and releases the masked outputs
// one at a time in index order, gated by clock-source lock.
//
//   state   | meaning
//   IDLE    | no sequence running, all outputs released
//   ASSERT  | masked outputs held high, counting STRETCH cycles of lock=1
//   RELEASE | clearing one masked output every STEP cycles, lowest index first
module cs_rst_seq
  import cs_rst_pkg::*;
#(
  parameter int                 NUM_OUT  = 9,
  parameter logic [NUM_OUT-1:0] DEV_MASK = 9'h186,
  parameter int                 STRETCH  = 16,
  parameter int                 STEP     = 4,
  parameter int                 CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lock,
  input  logic               rst_all_req,
  input  logic               rst_dev_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               busy,
  output logic               all_ready,
  output logic               dev_ready
);

  if ((NUM_OUT < 1) || (NUM_OUT > 32) || (STRETCH < 1) || (STEP < 1)
      || (STRETCH > (1 << CNT_W)) || (STEP > (1 << CNT_W))) begin : g_bad_param
    $error("cs_rst_seq: illegal NUM_OUT/STRETCH/STEP or CNT_W too small");
  end

  localparam logic [NUM_OUT-1:0] ALL_MASK   = '1;
  localparam logic [NUM_OUT-1:0] ONE        = NUM_OUT'(1);
  localparam logic [CNT_W-1:0]   STRETCH_TC = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0]   STEP_TC    = CNT_W'(STEP - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d, mode_new;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [5:0]         idx_q, idx_d, pos;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d, mask_cur;
  logic               all_ready_q, all_ready_d;
  logic               dev_ready_q, dev_ready_d;

  function automatic logic [NUM_OUT-1:0] mask_of(input mode_e m);
    return (m == MODE_ALL) ? ALL_MASK : DEV_MASK;
  endfunction

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    pos       = NONE;
    mask_cur  = mask_of(mode_q);
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    mode_new  = (rst_all_req || ((state_q != IDLE) && (mode_q == MODE_ALL))) ? MODE_ALL : MODE_DEV;

    // A request restarts from any state, re-asserting every bit of the (possibly wider) mask.
    if (rst_all_req || rst_dev_req) begin
      state_d   = ASSERT;
      mode_d    = mode_new;
      cnt_d     = '0;
      rst_out_d = rst_out_q | mask_of(mode_new);
    end else begin
      case (state_q)
        IDLE: ;
        ASSERT: begin
          if (!lock) begin
            cnt_d = '0;
          end else if (cnt_q == STRETCH_TC) begin
            pos   = first_set(32'(mask_cur));
            cnt_d = '0;
            idx_d = pos;
            if (pos == NONE) begin
              state_d = IDLE;
            end else begin
              rst_out_d = rst_out_q & ~(ONE << pos);
              state_d   = (next_set(32'(mask_cur), pos) == NONE) ? IDLE : RELEASE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RELEASE: begin
          if (!lock) begin
            state_d   = ASSERT;
            cnt_d     = '0;
            rst_out_d = rst_out_q | mask_cur;
          end else if (cnt_q == STEP_TC) begin
            pos       = next_set(32'(mask_cur), idx_q);
            cnt_d     = '0;
            idx_d     = pos;
            rst_out_d = rst_out_q & ~(ONE << pos);
            if (next_set(32'(mask_cur), pos) == NONE) state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d   = ASSERT;
          mode_d    = MODE_ALL;
          cnt_d     = '0;
          rst_out_d = ALL_MASK;
        end
      endcase
    end

    all_ready_d = ~|rst_out_d;
    dev_ready_d = ~|(rst_out_d & DEV_MASK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ASSERT;
      mode_q      <= MODE_ALL;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_out_q   <= ALL_MASK;
      all_ready_q <= 1'b0;
      dev_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_out_q   <= rst_out_d;
      all_ready_q <= all_ready_d;
      dev_ready_q <= dev_ready_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign busy      = (state_q != IDLE);
  assign all_ready = all_ready_q;
  assign dev_ready = dev_ready_q;

endmodule
